// File: rtl/stream_wrr_pkg.sv
// Shared types for the weighted round-robin stream scheduler.
package stream_wrr_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

endpackage

// File: rtl/stream_wrr_sched_fifo.sv
// Circular-buffer stream FIFO with optional fall-through and synchronous flush.
module stream_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         T            = logic,
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned UW          = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          testmode_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [UW-1:0] usage_o,
  input  T              data_i,
  input  logic          push_i,
  output T              data_o,
  input  logic          pop_i
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [UW-1:0] FULL_CNT = UW'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [UW-1:0] cnt_q, cnt_d;
  logic          push, pop, bypass;
  logic          unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q;
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_q];

  assign push   = push_i && !full_o;
  assign pop    = pop_i && !empty_o;
  // In fall-through mode an empty FIFO can hand a beat straight through.
  assign bypass = FALL_THROUGH && (cnt_q == '0) && push && pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else if (!bypass) begin
      if (push) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (push && !bypass && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/stream_wrr_sched.sv
// Weighted round-robin merge of N_INP streams into one buffered, index-tagged output.
module stream_wrr_sched
  import stream_wrr_pkg::*;
#(
  parameter int unsigned N_INP       = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter type         T           = logic [DATA_WIDTH-1:0],
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_QUANTUM = 16,
  localparam int unsigned IDX_W      = $clog2(N_INP),
  localparam int unsigned QW         = $clog2(MAX_QUANTUM + 1),
  localparam int unsigned UW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       testmode_i,
  input  logic                       pause_i,
  input  logic [N_INP-1:0][QW-1:0]   quantum_i,
  input  T     [N_INP-1:0]           inp_data_i,
  input  logic [N_INP-1:0]           inp_valid_i,
  output logic [N_INP-1:0]           inp_ready_o,
  output T                           oup_data_o,
  output logic [IDX_W-1:0]           oup_idx_o,
  output logic                       oup_valid_o,
  input  logic                       oup_ready_i,
  output logic [UW-1:0]              usage_o,
  output logic                       idle_o
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    T                 payload;
  } entry_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INP - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_INP);
  localparam logic [QW-1:0]    ONE_Q    = QW'(1);

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Rotate so that start sits at bit 0, find the first request, map back.
  function automatic logic [IDX_W-1:0] first_from(input logic [N_INP-1:0] req,
                                                  input logic [IDX_W-1:0] start);
    logic [2*N_INP-1:0] dbl;
    logic [N_INP-1:0]   rot;
    logic [IDX_W-1:0]   pos;
    logic [IDX_W:0]     sum;
    logic               found;
    dbl   = {req, req};
    rot   = N_INP'(dbl >> start);
    pos   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (!found) begin
        if (rot[0]) begin
          found = 1'b1;
        end else begin
          rot = rot >> 1;
          pos = pos + 1'b1;
        end
      end
    end
    sum = {1'b0, start} + {1'b0, pos};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[IDX_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [QW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] pick;
  logic             fifo_full, fifo_empty, push, pop;
  entry_t           push_entry, pop_entry;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    inp_ready_o = '0;
    push        = 1'b0;
    pick        = first_from(inp_valid_i, ptr_q);
    if (clr_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      sel_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause_i && (|inp_valid_i)) begin
            sel_d   = pick;
            cnt_d   = (quantum_i[pick] == '0) ? ONE_Q : quantum_i[pick];
            state_d = GRANT;
          end
        end
        GRANT: begin
          inp_ready_o[sel_q] = !fifo_full;
          if (!inp_valid_i[sel_q]) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(sel_q);
          end else if (!fifo_full) begin
            push = 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (cnt_q <= ONE_Q) begin
              state_d = IDLE;
              ptr_d   = wrap_inc(sel_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign push_entry.idx     = sel_q;
  assign push_entry.payload = inp_data_i[sel_q];

  assign pop = oup_ready_i && !fifo_empty;

  stream_fifo #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (FIFO_DEPTH),
    .T            (entry_t)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (clr_i),
    .testmode_i (testmode_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (usage_o),
    .data_i     (push_entry),
    .push_i     (push),
    .data_o     (pop_entry),
    .pop_i      (pop)
  );

  assign oup_valid_o = !fifo_empty;
  assign oup_idx_o   = pop_entry.idx;
  assign oup_data_o  = pop_entry.payload;
  assign idle_o      = (state_q == IDLE) && fifo_empty;

endmodule
